regfile_decode: RTL and testbench
=================================

REGFILE_DECODE -- requirements
Module: regfile_decode

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 insn_in  input  32  fetched instruction entering decode; rs = insn_in[25:21], rt = insn_in[20:16].
REQ-005 pc_in  input  32  PC of insn_in.
REQ-006 wb_data  input  32  write data from the writeback stage.
REQ-007 wb_reg  input  5  destination register from the writeback stage.
REQ-008 wb_we  input  1  register write enable from the writeback stage.
REQ-009 stall  input  1  hold the D/X pipeline register.
REQ-010 flush  input  1  squash the instruction entering D/X.
REQ-011 rs_data  output  32  registered rs operand.
REQ-012 rt_data  output  32  registered rt operand.
REQ-013 insn_out  output  32  registered instruction.
REQ-014 pc_out  output  32  registered PC.
REQ-015 valid_out  output  1  D/X holds a live instruction.

Function
REQ-016 The register file SHALL be 32 x 32-bit, with one write port and two read ports.
REQ-017 Write: on a clk edge with wb_we=1 and wb_reg!=0, regs[wb_reg] <= wb_data; a write with wb_reg=0 SHALL be ignored.
REQ-018 Register 0 SHALL always read 0, with or without bypass.
REQ-019 Read bypass: if wb_we=1, wb_reg!=0 and wb_reg equals the rs (or rt) field, the captured operand SHALL be wb_data rather than the array value (write-before-read in the same cycle).
REQ-020 Latency: operands, insn_out and pc_out SHALL appear one clk after insn_in is presented, with no stall or flush in that cycle.
REQ-021 Normal capture (stall=0, flush=0): D/X <= {bypassed rs, bypassed rt, insn_in, pc_in}; valid_out <= 1.
REQ-022 Stall (stall=1, flush=0): insn_out, pc_out and valid_out SHALL hold their values.
REQ-023 During a stall, a writeback with wb_we=1 and wb_reg!=0 that matches the held insn_out rs (or rt) field SHALL update the held rs_data (or rt_data) to wb_data, so that no stale operand survives the stall.
REQ-024 During a stall, held operands whose register is not written SHALL be unchanged.
REQ-025 Flush: D/X <= {0, 0, 32'h0 (NOP), pc_in}; valid_out <= 0.
REQ-026 Flush SHALL take priority over stall.
REQ-027 Register-file writes SHALL proceed regardless of stall or flush.
REQ-028 Priority SHALL be reset > flush > stall > normal capture.
REQ-029 If rs and rt name the same register, both operands SHALL receive the same value, including the bypassed value.

Reset
REQ-030 While reset=1 at a clk edge, all 32 registers, rs_data, rt_data, insn_out and pc_out SHALL become 0, and valid_out SHALL become 0.
REQ-031 A writeback asserted in the same cycle as reset SHALL be discarded.
REQ-032 A stall or flush asserted in the same cycle as reset SHALL be ignored.
REQ-033 Reset asserted mid-stall SHALL clear the held instruction.
REQ-034 On the first edge after reset is released, normal capture SHALL resume.

Verification
REQ-035 Reset, then present insn with rs=1, rt=2 -> next cycle rs_data=0, rt_data=0, valid_out=1.
REQ-036 Write r5=32'hDEADBEEF (wb_we=1) in the same cycle as an insn with rs=5 -> next cycle rs_data=32'hDEADBEEF (bypass), with no extra cycle.
REQ-037 wb_reg=0, wb_data=32'h1234, then an insn with rs=0, rt=0 -> rs_data=0, rt_data=0.
REQ-038 Hold stall=1 with insn_out rt=7, and write r7=32'hA5A5A5A5 during the stall -> rt_data=32'hA5A5A5A5 while insn_out and pc_out are unchanged; release stall -> the next insn is captured.
REQ-039 Assert flush and stall together with insn_in=32'h8C220004 -> insn_out=0, valid_out=0, and a concurrent write r3=9 still lands (a later read of r3 returns 9).
REQ-040 Write r4=32'hFF, then pulse reset with wb_we=1 on r4 -> a later read of r4 returns 0, and valid_out=0 during reset.

Source files
------------

// File: rtl/regfile_decode.sv
// Decode stage: 32x32 register file (1W/2R, write-before-read bypass) feeding
// the D/X pipeline register, with stall hold and flush squash.
module regfile_decode (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] insn_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] wb_data,
  input  logic [4:0]  wb_reg,
  input  logic        wb_we,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  output logic [31:0] insn_out,
  output logic [31:0] pc_out,
  output logic        valid_out
);

  logic [31:0] regs [32];

  logic        wb_hit;
  logic [4:0]  rs_a, rt_a, held_rs, held_rt;
  logic [31:0] rs_byp, rt_byp, rs_hold, rt_hold;

  assign wb_hit  = wb_we && (wb_reg != 5'd0);
  assign rs_a    = insn_in[25:21];
  assign rt_a    = insn_in[20:16];
  assign held_rs = insn_out[25:21];
  assign held_rt = insn_out[20:16];

  // Incoming operands see this cycle's writeback; held operands are patched by
  // a writeback to their register so nothing stale survives a stall.
  always_comb begin
    rs_byp  = '0;
    rt_byp  = '0;
    rs_hold = rs_data;
    rt_hold = rt_data;
    if (rs_a != 5'd0) rs_byp = (wb_hit && wb_reg == rs_a) ? wb_data : regs[rs_a];
    if (rt_a != 5'd0) rt_byp = (wb_hit && wb_reg == rt_a) ? wb_data : regs[rt_a];
    if (wb_hit && wb_reg == held_rs) rs_hold = wb_data;
    if (wb_hit && wb_reg == held_rt) rt_hold = wb_data;
  end

  // NOTE: the array is cleared on reset, so it maps to flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wb_hit) begin
      regs[wb_reg] <= wb_data;
    end
  end

  // NOTE: state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      rs_data   <= '0;
      rt_data   <= '0;
      insn_out  <= '0;
      pc_out    <= '0;
      valid_out <= 1'b0;
    end else if (flush) begin
      rs_data   <= '0;
      rt_data   <= '0;
      insn_out  <= '0;
      pc_out    <= pc_in;
      valid_out <= 1'b0;
    end else if (stall) begin
      rs_data   <= rs_hold;
      rt_data   <= rt_hold;
    end else begin
      rs_data   <= rs_byp;
      rt_data   <= rt_byp;
      insn_out  <= insn_in;
      pc_out    <= pc_in;
      valid_out <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_decode.sv
// Directed bench for regfile_decode: expected D/X contents are queued as each
// step is driven and popped for comparison one edge later.
module tb_regfile_decode;

  typedef struct packed {
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] insn;
    logic [31:0] pc;
    logic        valid;
  } dx_t;

  logic        clk = 1'b0;
  logic        reset, wb_we, stall, flush;
  logic [31:0] insn_in, pc_in, wb_data;
  logic [4:0]  wb_reg;
  logic [31:0] rs_data, rt_data, insn_out, pc_out;
  logic        valid_out;

  int errors = 0;
  int checks = 0;
  dx_t exp_q[$];

  regfile_decode dut (
    .clk(clk), .reset(reset), .insn_in(insn_in), .pc_in(pc_in),
    .wb_data(wb_data), .wb_reg(wb_reg), .wb_we(wb_we),
    .stall(stall), .flush(flush),
    .rs_data(rs_data), .rt_data(rt_data), .insn_out(insn_out),
    .pc_out(pc_out), .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt);
    return {6'd0, rs, rt, 16'h0020};
  endfunction

  function automatic dx_t dx(input logic [31:0] rs, input logic [31:0] rt,
                             input logic [31:0] insn, input logic [31:0] pc,
                             input logic valid);
    dx_t d;
    d.rs = rs; d.rt = rt; d.insn = insn; d.pc = pc; d.valid = valid;
    return d;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic stl, input logic fl,
                       input logic [31:0] insn, input logic [31:0] pc,
                       input logic we, input logic [4:0] wreg, input logic [31:0] wdata);
    reset = rst; stall = stl; flush = fl;
    insn_in = insn; pc_in = pc;
    wb_we = we; wb_reg = wreg; wb_data = wdata;
  endtask

  // Push the expectation for the driven inputs, clock once, then compare.
  task automatic cycle(input string tag, input dx_t e);
    dx_t got;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: scoreboard empty", tag);
    end else begin
      got = exp_q.pop_front();
      check({tag, ".rs"},    rs_data,  got.rs);
      check({tag, ".rt"},    rt_data,  got.rt);
      check({tag, ".insn"},  insn_out, got.insn);
      check({tag, ".pc"},    pc_out,   got.pc);
      check({tag, ".valid"}, {31'd0, valid_out}, {31'd0, got.valid});
    end
  endtask

  initial begin
    drive(1'b1, 1'b1, 1'b1, mk(5'd1, 5'd2), 32'h100, 1'b1, 5'd9, 32'h99);
    @(negedge clk);
    cycle("reset_all", dx(32'h0, 32'h0, 32'h0, 32'h0, 1'b0));

    drive(1'b0, 1'b0, 1'b0, mk(5'd1, 5'd2), 32'h100, 1'b0, 5'd0, 32'h0);
    cycle("first_capture", dx(32'h0, 32'h0, mk(5'd1, 5'd2), 32'h100, 1'b1));

    drive(1'b0, 1'b0, 1'b0, mk(5'd9, 5'd0), 32'h102, 1'b0, 5'd0, 32'h0);
    cycle("reset_wb_dropped", dx(32'h0, 32'h0, mk(5'd9, 5'd0), 32'h102, 1'b1));

    drive(1'b0, 1'b0, 1'b0, mk(5'd5, 5'd0), 32'h104, 1'b1, 5'd5, 32'hDEADBEEF);
    cycle("bypass_rs", dx(32'hDEADBEEF, 32'h0, mk(5'd5, 5'd0), 32'h104, 1'b1));

    drive(1'b0, 1'b0, 1'b0, mk(5'd5, 5'd5), 32'h108, 1'b0, 5'd0, 32'h0);
    cycle("array_same_reg", dx(32'hDEADBEEF, 32'hDEADBEEF, mk(5'd5, 5'd5), 32'h108, 1'b1));

    drive(1'b0, 1'b0, 1'b0, mk(5'd0, 5'd0), 32'h10C, 1'b1, 5'd0, 32'h1234);
    cycle("r0_write_ignored", dx(32'h0, 32'h0, mk(5'd0, 5'd0), 32'h10C, 1'b1));

    drive(1'b0, 1'b0, 1'b0, mk(5'd6, 5'd6), 32'h110, 1'b1, 5'd6, 32'h66);
    cycle("bypass_same_reg", dx(32'h66, 32'h66, mk(5'd6, 5'd6), 32'h110, 1'b1));

    drive(1'b0, 1'b0, 1'b0, mk(5'd6, 5'd7), 32'h114, 1'b0, 5'd0, 32'h0);
    cycle("pre_stall", dx(32'h66, 32'h0, mk(5'd6, 5'd7), 32'h114, 1'b1));

    drive(1'b0, 1'b1, 1'b0, mk(5'd1, 5'd1), 32'h200, 1'b1, 5'd7, 32'hA5A5A5A5);
    cycle("stall_patch_rt", dx(32'h66, 32'hA5A5A5A5, mk(5'd6, 5'd7), 32'h114, 1'b1));

    drive(1'b0, 1'b1, 1'b0, mk(5'd1, 5'd1), 32'h204, 1'b1, 5'd6, 32'h600);
    cycle("stall_patch_rs", dx(32'h600, 32'hA5A5A5A5, mk(5'd6, 5'd7), 32'h114, 1'b1));

    drive(1'b0, 1'b1, 1'b0, mk(5'd1, 5'd1), 32'h208, 1'b1, 5'd8, 32'h888);
    cycle("stall_unrelated_wb", dx(32'h600, 32'hA5A5A5A5, mk(5'd6, 5'd7), 32'h114, 1'b1));

    drive(1'b0, 1'b0, 1'b0, mk(5'd7, 5'd8), 32'h118, 1'b0, 5'd0, 32'h0);
    cycle("stall_release", dx(32'hA5A5A5A5, 32'h888, mk(5'd7, 5'd8), 32'h118, 1'b1));

    drive(1'b0, 1'b1, 1'b1, 32'h8C220004, 32'h11C, 1'b1, 5'd3, 32'd9);
    cycle("flush_over_stall", dx(32'h0, 32'h0, 32'h0, 32'h11C, 1'b0));

    drive(1'b0, 1'b0, 1'b0, mk(5'd3, 5'd0), 32'h120, 1'b0, 5'd0, 32'h0);
    cycle("flush_wb_landed", dx(32'd9, 32'h0, mk(5'd3, 5'd0), 32'h120, 1'b1));

    drive(1'b0, 1'b0, 1'b0, mk(5'd4, 5'd0), 32'h124, 1'b1, 5'd4, 32'hFF);
    cycle("write_r4", dx(32'hFF, 32'h0, mk(5'd4, 5'd0), 32'h124, 1'b1));

    drive(1'b0, 1'b1, 1'b0, mk(5'd1, 5'd1), 32'h300, 1'b0, 5'd0, 32'h0);
    cycle("stall_before_reset", dx(32'hFF, 32'h0, mk(5'd4, 5'd0), 32'h124, 1'b1));

    drive(1'b1, 1'b1, 1'b0, mk(5'd4, 5'd4), 32'h128, 1'b1, 5'd4, 32'h44);
    cycle("reset_mid_stall", dx(32'h0, 32'h0, 32'h0, 32'h0, 1'b0));

    drive(1'b0, 1'b0, 1'b0, mk(5'd4, 5'd3), 32'h12C, 1'b0, 5'd0, 32'h0);
    cycle("post_reset_read", dx(32'h0, 32'h0, mk(5'd4, 5'd3), 32'h12C, 1'b1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
